// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron datapath and its AXI4-Lite weight loader:
// loader FSM states, AXI response codes and the word stride.
package perceptron_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_WRITE     = 3'd2,
    ST_WAIT_B    = 3'd3,
    ST_RD_ADDR   = 3'd4,
    ST_RD_DATA   = 3'd5,
    ST_NEXT      = 3'd6,
    ST_DONE      = 3'd7
  } ldr_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned WORD_STRIDE = 4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/axil_wr_hs.sv
// AXI4-Lite AW/W handshake tracker: both valids rise together on launch, each drops on
// its own handshake, and both_done pulses in the cycle the last outstanding one completes.
module axil_wr_hs (
  input  logic clk,
  input  logic rst_n,
  input  logic i_launch,
  input  logic i_awready,
  input  logic i_wready,
  output logic o_awvalid,
  output logic o_wvalid,
  output logic o_both_done
);

  logic r_awvalid;
  logic r_wvalid;
  logic r_active;
  logic w_aw_ok;
  logic w_w_ok;

  // A channel is "ok" once its handshake happened earlier or is happening this cycle.
  assign w_aw_ok     = ~r_awvalid | i_awready;
  assign w_w_ok      = ~r_wvalid | i_wready;
  assign o_both_done = r_active & w_aw_ok & w_w_ok;

  assign o_awvalid = r_awvalid;
  assign o_wvalid  = r_wvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_active  <= 1'b0;
    end else if (i_launch) begin
      r_awvalid <= 1'b1;
      r_wvalid  <= 1'b1;
      r_active  <= 1'b1;
    end else begin
      if (r_awvalid && i_awready) r_awvalid <= 1'b0;
      if (r_wvalid && i_wready)   r_wvalid  <= 1'b0;
      if (o_both_done)            r_active  <= 1'b0;
    end
  end

endmodule

// File: rtl/axil_weight_loader.sv
// AXI4-Lite master writing `count` stream words to consecutive word addresses from base_addr.
// Define AXIL_WEIGHT_LOADER_VERIFY_EN to read each word back and compare against what was written.
module axil_weight_loader
  import perceptron_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 10
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic [31:0]       w_tdata,
  input  logic              w_tvalid,
  output logic              w_tready,
  output logic [ADDR_W-1:0] M_AXI_awaddr,
  output logic [2:0]        M_AXI_awprot,
  output logic              M_AXI_awvalid,
  input  logic              M_AXI_awready,
  output logic [31:0]       M_AXI_wdata,
  output logic [3:0]        M_AXI_wstrb,
  output logic              M_AXI_wvalid,
  input  logic              M_AXI_wready,
  input  logic [1:0]        M_AXI_bresp,
  input  logic              M_AXI_bvalid,
  output logic              M_AXI_bready,
  output logic [ADDR_W-1:0] M_AXI_araddr,
  output logic [2:0]        M_AXI_arprot,
  output logic              M_AXI_arvalid,
  input  logic              M_AXI_arready,
  input  logic [31:0]       M_AXI_rdata,
  input  logic [1:0]        M_AXI_rresp,
  input  logic              M_AXI_rvalid,
  output logic              M_AXI_rready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        err_count
);

  ldr_state_e        r_state;
  ldr_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_remain;
  logic [31:0]       r_hold;
  logic              r_error;
  logic [7:0]        r_err_count;
  logic              w_accept;
  logic              w_launch;
  logic              w_both_done;
  logic              w_err_ev;
  logic              w_unused;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_launch = (r_state == ST_WAIT_DATA) && w_tvalid;

  axil_wr_hs u_wr_hs (
    .clk         (s_axi_aclk),
    .rst_n       (s_axi_aresetn),
    .i_launch    (w_launch),
    .i_awready   (M_AXI_awready),
    .i_wready    (M_AXI_wready),
    .o_awvalid   (M_AXI_awvalid),
    .o_wvalid    (M_AXI_wvalid),
    .o_both_done (w_both_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (start) w_state_nxt = (count == '0) ? ST_DONE : ST_WAIT_DATA;
      ST_WAIT_DATA: if (w_tvalid) w_state_nxt = ST_WRITE;
      ST_WRITE:     if (w_both_done) w_state_nxt = ST_WAIT_B;
`ifdef AXIL_WEIGHT_LOADER_VERIFY_EN
      ST_WAIT_B:    if (M_AXI_bvalid) w_state_nxt = ST_RD_ADDR;
      ST_RD_ADDR:   if (M_AXI_arready) w_state_nxt = ST_RD_DATA;
      ST_RD_DATA:   if (M_AXI_rvalid) w_state_nxt = ST_NEXT;
`else
      ST_WAIT_B:    if (M_AXI_bvalid) w_state_nxt = ST_NEXT;
`endif
      // r_remain still holds the pre-decrement value here, so 1 means this was the last word.
      ST_NEXT:      w_state_nxt = (r_remain == CNT_W'(1)) ? ST_DONE : ST_WAIT_DATA;
      ST_DONE:      w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_err_ev = (r_state == ST_WAIT_B) && M_AXI_bvalid && (M_AXI_bresp != RESP_OKAY);
`ifdef AXIL_WEIGHT_LOADER_VERIFY_EN
    if ((r_state == ST_RD_DATA) && M_AXI_rvalid &&
        ((M_AXI_rresp != RESP_OKAY) || (M_AXI_rdata != r_hold)))
      w_err_ev = 1'b1;
`endif
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remain    <= '0;
      r_hold      <= '0;
      r_error     <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_error     <= 1'b0;
        r_err_count <= '0;
        if (count != '0) begin
          r_addr   <= {base_addr[ADDR_W-1:2], 2'b00};
          r_remain <= count;
        end
      end
      if (w_launch) r_hold <= w_tdata;
      if (r_state == ST_NEXT) begin
        r_addr   <= r_addr + ADDR_W'(WORD_STRIDE);
        r_remain <= r_remain - CNT_W'(1);
      end
      if (w_err_ev) begin
        r_error     <= 1'b1;
        r_err_count <= sat_inc8(r_err_count);
      end
    end
  end

  assign busy         = (r_state != ST_IDLE);
  assign done         = (r_state == ST_DONE);
  assign w_tready     = (r_state == ST_WAIT_DATA);
  assign M_AXI_bready = (r_state == ST_WAIT_B);
  assign M_AXI_awaddr = r_addr;
  assign M_AXI_awprot = 3'b000;
  assign M_AXI_wdata  = r_hold;
  assign M_AXI_wstrb  = 4'b1111;
  assign M_AXI_arprot = 3'b000;
  assign error        = r_error;
  assign err_count    = r_err_count;

`ifdef AXIL_WEIGHT_LOADER_VERIFY_EN
  assign M_AXI_arvalid = (r_state == ST_RD_ADDR);
  assign M_AXI_araddr  = r_addr;
  assign M_AXI_rready  = (r_state == ST_RD_DATA);
  assign w_unused      = &{1'b0, base_addr[1:0]};
`else
  assign M_AXI_arvalid = 1'b0;
  assign M_AXI_araddr  = '0;
  assign M_AXI_rready  = 1'b0;
  assign w_unused      = &{1'b0, base_addr[1:0], M_AXI_arready, M_AXI_rdata, M_AXI_rresp, M_AXI_rvalid};
`endif

endmodule

// File: tb/tb_axil_weight_loader.sv
// Testbench for axil_weight_loader: randomized AXI4-Lite slave and weight stream with
// independent per-channel delays, checked against a queue-based reference of the expected load.
module tb_axil_weight_loader;

  localparam int CNT_W = 10;
`ifdef AXIL_WEIGHT_LOADER_VERIFY_EN
  localparam bit VERIFY   = 1'b1;
  localparam int PER_WORD = 6;
`else
  localparam bit VERIFY   = 1'b0;
  localparam int PER_WORD = 4;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, w_tvalid, w_tready, busy, done, error;
  logic [31:0] base_addr, w_tdata, awaddr, wdata, araddr, rdata;
  logic [CNT_W-1:0] count;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [7:0]  err_count;

  axil_weight_loader #(.ADDR_W(32), .CNT_W(CNT_W)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .w_tdata(w_tdata), .w_tvalid(w_tvalid), .w_tready(w_tready),
    .M_AXI_awaddr(awaddr), .M_AXI_awprot(awprot), .M_AXI_awvalid(awvalid), .M_AXI_awready(awready),
    .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb), .M_AXI_wvalid(wvalid), .M_AXI_wready(wready),
    .M_AXI_bresp(bresp), .M_AXI_bvalid(bvalid), .M_AXI_bready(bready),
    .M_AXI_araddr(araddr), .M_AXI_arprot(arprot), .M_AXI_arvalid(arvalid), .M_AXI_arready(arready),
    .M_AXI_rdata(rdata), .M_AXI_rresp(rresp), .M_AXI_rvalid(rvalid), .M_AXI_rready(rready),
    .busy(busy), .done(done), .error(error), .err_count(err_count)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Configuration and stimulus owned by the main sequence
  logic [31:0] stim [0:1023];
  int stim_n = 0;
  bit slv_clear = 1'b0;
  int max_dly = 0;
  int err_wr_idx = -1;   // -1 none, -2 every write
  int bad_rd_idx = -1;
  int rresp_rd_idx = -1;

  // State owned by the slave/stream/monitor process
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
  logic [31:0] pend_aw[$], pend_w[$], pend_ar[$];
  logic [31:0] sa, sd, st_awaddr, st_wdata, st_araddr;
  int wr_idx, rd_idx, stim_pos, aw_dly, w_dly, b_dly, r_dly, ar_dly, t_gap;
  int done_cnt, stab_viol;
  bit t_fired, b_fired, r_fired, valid_seen, st_aw, st_w, st_ar;

  function automatic int rnd_dly();
    return int'($urandom_range(0, max_dly));
  endfunction

  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
    rvalid = 0; rresp = 0; rdata = 0; w_tvalid = 0; w_tdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || slv_clear) begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
        rvalid = 0; rresp = 0; rdata = 0; w_tvalid = 0; w_tdata = 0;
        pend_aw.delete(); pend_w.delete(); pend_ar.delete();
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        wr_idx = 0; rd_idx = 0; stim_pos = 0; done_cnt = 0; stab_viol = 0; valid_seen = 0;
        t_fired = 0; b_fired = 0; r_fired = 0; st_aw = 0; st_w = 0; st_ar = 0;
        aw_dly = rnd_dly(); w_dly = rnd_dly(); b_dly = rnd_dly();
        r_dly = rnd_dly(); ar_dly = rnd_dly(); t_gap = rnd_dly();
      end else begin
        if (done) done_cnt++;
        if (awvalid || wvalid || arvalid || w_tready) valid_seen = 1;
        if (st_aw && (!awvalid || awaddr !== st_awaddr)) stab_viol++;
        if (st_w && (!wvalid || wdata !== st_wdata)) stab_viol++;
        if (st_ar && (!arvalid || araddr !== st_araddr)) stab_viol++;
        if (awprot !== 3'b000 || arprot !== 3'b000 || wstrb !== 4'b1111) stab_viol++;
        if (!VERIFY && (arvalid || rready || araddr !== 32'h0)) stab_viol++;
        // Weight stream
        if (t_fired) begin t_fired = 0; w_tvalid = 0; t_gap = rnd_dly(); end
        if (!w_tvalid && stim_pos < stim_n) begin
          if (t_gap > 0) t_gap--;
          else begin w_tvalid = 1; w_tdata = stim[stim_pos]; end
        end
        if (w_tvalid && w_tready) begin t_fired = 1; stim_pos++; end
        // Write response, only after both AW and W handshakes have completed
        if (b_fired) begin b_fired = 0; bvalid = 0; bresp = 0; b_dly = rnd_dly(); end
        if (!bvalid && pend_aw.size() > 0 && pend_w.size() > 0) begin
          if (b_dly > 0) b_dly--;
          else begin
            sa = pend_aw.pop_front(); sd = pend_w.pop_front();
            mem[sa] = sd; wr_addr_q.push_back(sa); wr_data_q.push_back(sd);
            bvalid = 1;
            bresp = (err_wr_idx == -2 || err_wr_idx == wr_idx) ? 2'b10 : 2'b00;
            wr_idx++;
          end
        end
        if (bvalid && bready) b_fired = 1;
        awready = 0;
        if (awvalid) begin
          if (aw_dly > 0) aw_dly--;
          else begin awready = 1; pend_aw.push_back(awaddr); aw_dly = rnd_dly(); end
        end
        wready = 0;
        if (wvalid) begin
          if (w_dly > 0) w_dly--;
          else begin wready = 1; pend_w.push_back(wdata); w_dly = rnd_dly(); end
        end
        // Read data, then read address
        if (r_fired) begin r_fired = 0; rvalid = 0; rresp = 0; rdata = 0; r_dly = rnd_dly(); end
        if (!rvalid && pend_ar.size() > 0) begin
          if (r_dly > 0) r_dly--;
          else begin
            sa = pend_ar.pop_front();
            rdata = mem.exists(sa) ? mem[sa] : 32'h0;
            if (rd_idx == bad_rd_idx) rdata = rdata ^ 32'h0000_0100;
            rresp = (rd_idx == rresp_rd_idx) ? 2'b10 : 2'b00;
            rd_idx++;
            rvalid = 1;
          end
        end
        if (rvalid && rready) r_fired = 1;
        arready = 0;
        if (arvalid) begin
          if (ar_dly > 0) ar_dly--;
          else begin arready = 1; pend_ar.push_back(araddr); rd_addr_q.push_back(araddr); ar_dly = rnd_dly(); end
        end
        st_aw = awvalid && !awready; st_awaddr = awaddr;
        st_w  = wvalid && !wready;   st_wdata  = wdata;
        st_ar = arvalid && !arready; st_araddr = araddr;
      end
    end
  end

  // Reference model: word i goes to (base with low bits cleared) + 4*i, modulo 2^32
  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int i);
    return (base & 32'hFFFF_FFFC) + 32'(4 * i);
  endfunction

  function automatic int exp_errs(input int n, input int ew, input int br, input int rr);
    int e = 0;
    for (int i = 0; i < n; i++) begin
      if (ew == -2 || ew == i) e++;
      if (VERIFY && (i == br || i == rr)) e++;
    end
    return (e > 255) ? 255 : e;
  endfunction

  function automatic int wr_diffs(input logic [31:0] base, input int n);
    int d = (wr_addr_q.size() != n) ? 1 : 0;
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      if (wr_addr_q[i] !== exp_addr(base, i)) d++;
      if (wr_data_q[i] !== stim[i]) d++;
    end
    return d;
  endfunction

  function automatic int rd_diffs(input logic [31:0] base, input int n);
    int m = VERIFY ? n : 0;
    int d = (rd_addr_q.size() != m) ? 1 : 0;
    for (int i = 0; i < m && i < rd_addr_q.size(); i++)
      if (rd_addr_q[i] !== exp_addr(base, i)) d++;
    return d;
  endfunction

  task automatic set_cfg(input int dly, input int ew, input int br, input int rr);
    max_dly = dly; err_wr_idx = ew; bad_rd_idx = br; rresp_rd_idx = rr;
  endtask

  task automatic fill_stim(input int n);
    for (int i = 0; i < n; i++) stim[i] = $urandom;
  endtask

  task automatic run_load(input logic [31:0] base, input int n, input int restart_at, input int budget,
                          output int cycles, output bit to, output bit busy_pre, output bit busy_post);
    stim_n = n;
    @(negedge clk); slv_clear = 1;
    repeat (2) @(negedge clk);
    slv_clear = 0;
    @(negedge clk);
    base_addr = base; count = CNT_W'(n); start = 1; busy_pre = busy;
    @(posedge clk); #1;
    start = 0; busy_post = busy;
    cycles = 0;
    while (!done && cycles < budget) begin
      start = (restart_at >= 0) && (cycles == restart_at);
      if (start) count = CNT_W'(n + 3);
      @(posedge clk); #1;
      cycles++;
    end
    start = 0;
    to = !done;
    if (to) begin rst_n = 0; #2; rst_n = 1; end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; base_addr = 0; count = 0;
    #1;
    n_cmp++; if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b expected 000", {busy, done, error}); end
    n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
    n_cmp++; if ({awvalid, wvalid, bready, arvalid, rready, w_tready} !== 6'b0) begin n_fail++; $display("FAIL reset_handshake: got %b expected 000000", {awvalid, wvalid, bready, arvalid, rready, w_tready}); end
    n_cmp++; if ({awaddr, wdata, araddr} !== 96'h0) begin n_fail++; $display("FAIL reset_addr_data: got %h expected 0", {awaddr, wdata, araddr}); end
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy=%b expected 0", busy); end
  endtask

  task automatic test_basic();
    int cyc; bit to, bpre, bpost;
    set_cfg(0, -1, -1, -1);
    for (int i = 0; i < 5; i++) stim[i] = 32'(i + 1);
    run_load(32'h0, 5, -1, 200, cyc, to, bpre, bpost);
    n_cmp++; if (to || cyc != PER_WORD * 5) begin n_fail++; $display("FAIL basic_latency: got %0d cycles (timeout=%0b) expected %0d", cyc, to, PER_WORD * 5); end
    n_cmp++; if ({bpre, bpost} !== 2'b01) begin n_fail++; $display("FAIL basic_busy_rise: got %b expected 01", {bpre, bpost}); end
    n_cmp++; if (wr_diffs(32'h0, 5) != 0) begin n_fail++; $display("FAIL basic_writes: got %0d bad entries expected 0", wr_diffs(32'h0, 5)); end
    n_cmp++; if (rd_diffs(32'h0, 5) != 0) begin n_fail++; $display("FAIL basic_reads: got %0d bad entries expected 0", rd_diffs(32'h0, 5)); end
    n_cmp++; if (done_cnt != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: done cycles %0d busy %b expected 1 and 0", done_cnt, busy); end
    n_cmp++; if ({error, err_count} !== 9'd0) begin n_fail++; $display("FAIL basic_error: got %b/%0d expected 0/0", error, err_count); end
  endtask

  task automatic test_count_zero();
    int cyc; bit to, bpre, bpost;
    set_cfg(0, -1, -1, -1);
    run_load($urandom, 0, -1, 20, cyc, to, bpre, bpost);
    n_cmp++; if (to || cyc != 0) begin n_fail++; $display("FAIL zero_latency: got %0d extra cycles (timeout=%0b) expected 0", cyc, to); end
    n_cmp++; if (valid_seen !== 1'b0 || wr_addr_q.size() != 0) begin n_fail++; $display("FAIL zero_traffic: valid_seen %b writes %0d expected 0 and 0", valid_seen, wr_addr_q.size()); end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done_pulse: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    int cyc, n; bit to, bpre, bpost; logic [31:0] base;
    for (int k = 0; k < 3; k++) begin
      set_cfg(50, -1, -1, -1);
      n = int'($urandom_range(3, 8));
      base = {$urandom_range(0, 32'h0FFF), 2'b00} << 2;
      fill_stim(n);
      run_load(base, n, -1, 20000, cyc, to, bpre, bpost);
      n_cmp++; if (to) begin n_fail++; $display("FAIL bp_timeout[%0d]: got timeout expected done", k); end
      n_cmp++; if (wr_diffs(base, n) != 0 || rd_diffs(base, n) != 0) begin n_fail++; $display("FAIL bp_transfers[%0d]: got %0d/%0d bad expected 0/0", k, wr_diffs(base, n), rd_diffs(base, n)); end
      n_cmp++; if (stab_viol != 0 || done_cnt != 1 || error !== 1'b0) begin n_fail++; $display("FAIL bp_protocol[%0d]: violations %0d done %0d error %b expected 0 1 0", k, stab_viol, done_cnt, error); end
    end
  endtask

  task automatic test_error_inject();
    int cyc; bit to, bpre, bpost; int e;
    set_cfg(5, 2, -1, -1);
    fill_stim(5);
    run_load(32'h200, 5, -1, 5000, cyc, to, bpre, bpost);
    e = exp_errs(5, 2, -1, -1);
    n_cmp++; if (to || wr_diffs(32'h200, 5) != 0) begin n_fail++; $display("FAIL err_writes: got %0d bad (timeout=%0b) expected 0", wr_diffs(32'h200, 5), to); end
    n_cmp++; if (error !== 1'b1 || err_count !== 8'(e)) begin n_fail++; $display("FAIL err_flags: got %b/%0d expected 1/%0d", error, err_count, e); end
    set_cfg(0, -1, -1, -1);
    run_load(32'h0, 0, -1, 20, cyc, to, bpre, bpost);
    n_cmp++; if (error !== 1'b0 || err_count !== 8'd0) begin n_fail++; $display("FAIL err_clear: got %b/%0d expected 0/0", error, err_count); end
  endtask

`ifdef AXIL_WEIGHT_LOADER_VERIFY_EN
  task automatic test_verify();
    int cyc; bit to, bpre, bpost;
    set_cfg(10, -1, 1, 3);
    fill_stim(5);
    run_load(32'h1000, 5, -1, 8000, cyc, to, bpre, bpost);
    n_cmp++; if (to || err_count !== 8'd2 || error !== 1'b1) begin n_fail++; $display("FAIL verify_errors: got %b/%0d (timeout=%0b) expected 1/2", error, err_count, to); end
    n_cmp++; if (rd_diffs(32'h1000, 5) != 0 || wr_diffs(32'h1000, 5) != 0) begin n_fail++; $display("FAIL verify_reads: got %0d bad reads %0d bad writes expected 0/0", rd_diffs(32'h1000, 5), wr_diffs(32'h1000, 5)); end
  endtask
`endif

  task automatic test_wrap_align();
    int cyc; bit to, bpre, bpost;
    set_cfg(2, -1, -1, -1);
    fill_stim(4);
    run_load(32'hFFFF_FFF9, 4, -1, 2000, cyc, to, bpre, bpost);
    n_cmp++; if (to || wr_diffs(32'hFFFF_FFF9, 4) != 0) begin n_fail++; $display("FAIL wrap_writes: got %0d bad (timeout=%0b) expected 0", wr_diffs(32'hFFFF_FFF9, 4), to); end
    n_cmp++; if (wr_addr_q.size() == 4 && wr_addr_q[2] !== 32'h0) begin n_fail++; $display("FAIL wrap_third_addr: got %h expected 00000000", wr_addr_q[2]); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit to, bpre, bpost;
    set_cfg(3, -1, -1, -1);
    fill_stim(6);
    run_load(32'h300, 6, 5, 5000, cyc, to, bpre, bpost);
    repeat (10) @(negedge clk);
    n_cmp++; if (to || wr_diffs(32'h300, 6) != 0) begin n_fail++; $display("FAIL busy_start_writes: got %0d bad (timeout=%0b) expected 0", wr_diffs(32'h300, 6), to); end
    n_cmp++; if (done_cnt != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_ignored: done %0d busy %b expected 1 and 0", done_cnt, busy); end
  endtask

  task automatic test_saturate();
    int cyc; bit to, bpre, bpost;
    set_cfg(0, -2, -1, -1);
    fill_stim(300);
    run_load(32'h0, 300, -1, 3000, cyc, to, bpre, bpost);
    n_cmp++; if (to || err_count !== 8'd255 || error !== 1'b1) begin n_fail++; $display("FAIL saturate: got %b/%0d (timeout=%0b) expected 1/255", error, err_count, to); end
    n_cmp++; if (wr_diffs(32'h0, 300) != 0) begin n_fail++; $display("FAIL saturate_writes: got %0d bad expected 0", wr_diffs(32'h0, 300)); end
  endtask

  task automatic test_reset_midload();
    int c, cyc; bit to, bpre, bpost;
    set_cfg(3, 0, -1, -1);
    fill_stim(5);
    stim_n = 5;
    @(negedge clk); slv_clear = 1;
    repeat (2) @(negedge clk);
    slv_clear = 0;
    @(negedge clk);
    base_addr = 32'h40; count = CNT_W'(5); start = 1;
    @(posedge clk); #1;
    start = 0;
    c = 0;
    while (!(awvalid && wr_idx == 1) && c < 2000) begin @(posedge clk); #1; c++; end
    n_cmp++; if (!(awvalid && wr_idx == 1) || error !== 1'b1) begin n_fail++; $display("FAIL midload_reach: awvalid %b words %0d error %b expected 1 1 1", awvalid, wr_idx, error); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if ({busy, done, error, err_count} !== 11'd0) begin n_fail++; $display("FAIL midload_reset_status: got %b expected 0", {busy, done, error, err_count}); end
    n_cmp++; if ({awvalid, wvalid, bready, arvalid, rready, w_tready} !== 6'b0 || {awaddr, wdata, araddr} !== 96'h0) begin n_fail++; $display("FAIL midload_reset_axi: got %b/%h expected 0/0", {awvalid, wvalid, bready, arvalid, rready, w_tready}, {awaddr, wdata, araddr}); end
    repeat (3) @(negedge clk);
    rst_n = 1;
    set_cfg(4, -1, -1, -1);
    fill_stim(6);
    run_load(32'h80, 6, -1, 5000, cyc, to, bpre, bpost);
    n_cmp++; if (to || wr_diffs(32'h80, 6) != 0 || rd_diffs(32'h80, 6) != 0) begin n_fail++; $display("FAIL midload_fresh_load: got %0d bad (timeout=%0b) expected 0", wr_diffs(32'h80, 6), to); end
    n_cmp++; if (error !== 1'b0 || done_cnt != 1) begin n_fail++; $display("FAIL midload_fresh_status: error %b done %0d expected 0 1", error, done_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_count_zero();
    test_backpressure();
    test_error_inject();
`ifdef AXIL_WEIGHT_LOADER_VERIFY_EN
    test_verify();
`endif
    test_wrap_align();
    test_back_to_back();
    test_saturate();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
